// File: rtl/multdiv_iter_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Holds the FSM encoding, the last iteration index and the product range check.
package multdiv_iter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0]  ITER_LAST = 5'd31;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // True when product bits [63:31] are a pure sign extension, i.e. the low word is exact.
  function automatic logic fits_low_word(input logic [32:0] upper);
    return (&upper) | ~(|upper);
  endfunction

endpackage

// File: rtl/multdiv_iter_if.sv
// Operand/control/result bundle between the execute stage and the multiply/divide unit.
// The execute stage is the master; the unit is the slave.
interface multdiv_iter_if;

  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/multdiv_iter_add_sub_33.sv
// 33-bit combinational adder/subtractor shared by Booth steps and divide trial subtracts.
// With sub=1 the result is a-b and cout=1 means no borrow (a >= b, unsigned).
module add_sub_33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum,
  output logic        cout
);

  logic [33:0] full;

  assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {33'd0, sub};
  assign sum  = full[32:0];
  assign cout = full[33];

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply (radix-2 Booth) and divide (restoring on magnitudes).
// Fixed 33-cycle busy window per operation; a new start always aborts the current one.
module multdiv_iter
  import multdiv_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  multdiv_iter_if.slave bus
);

  state_t             state;
  logic [4:0]         counter;
  logic [32:0]        a_reg;
  logic [64:0]        work;
  logic               op_is_div;
  logic               sign_q;

  logic               start;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [32:0]        add_a;
  logic               add_sub;
  logic [32:0]        add_sum;
  logic               add_cout;
  logic [32:0]        mul_ns;
  logic [32:0]        div_shift;
  logic [32:0]        div_rem;
  logic [64:0]        work_next;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   fin_result;
  logic               fin_exc;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign mag_a = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
  assign mag_b = bus.data_operandB[31] ? -bus.data_operandB : bus.data_operandB;

  add_sub_33 u_add_sub (
    .a    (add_a),
    .b    (a_reg),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // MUL work layout: {hi[31:0], lo[31:0], q_minus1}; DIV layout: {rem[32:0], quot[31:0]}.
  always_comb begin
    div_shift  = {work[63:32], work[31]};
    add_a      = op_is_div ? div_shift : {work[64], work[64:33]};
    add_sub    = op_is_div | work[1];
    mul_ns     = (work[1] ^ work[0]) ? add_sum : add_a;
    div_rem    = add_cout ? add_sum : div_shift;
    work_next  = op_is_div ? {div_rem, work[30:0], add_cout} : {mul_ns, work[32:1]};
    quot       = work_next[31:0];
    fin_result = '0;
    fin_exc    = 1'b0;
    if (!op_is_div) begin
      fin_result = work_next[32:1];
      fin_exc    = ~fits_low_word(work_next[64:32]);
    end else if (a_reg == 33'd0) begin
      fin_result = '0;
      fin_exc    = 1'b1;
    end else begin
      // Only INT_MIN / -1 yields a positive quotient of 2^31.
      fin_result = sign_q ? -quot : quot;
      fin_exc    = ~sign_q & quot[31];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      counter            <= 5'd0;
      a_reg              <= 33'd0;
      work               <= 65'd0;
      op_is_div          <= 1'b0;
      sign_q             <= 1'b0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;
      if (start) begin
        counter            <= 5'd0;
        bus.busy           <= 1'b1;
        bus.data_result    <= '0;
        bus.data_exception <= 1'b0;
        if (bus.ctrl_MULT) begin
          state     <= S_MUL;
          op_is_div <= 1'b0;
          sign_q    <= 1'b0;
          a_reg     <= {bus.data_operandA[31], bus.data_operandA};
          work      <= {32'd0, bus.data_operandB, 1'b0};
        end else begin
          state     <= S_DIV;
          op_is_div <= 1'b1;
          sign_q    <= bus.data_operandA[31] ^ bus.data_operandB[31];
          a_reg     <= {1'b0, mag_b};
          work      <= {33'd0, mag_a};
        end
      end else begin
        case (state)
          S_MUL, S_DIV: begin
            work <= work_next;
            if (counter == ITER_LAST) begin
              counter            <= 5'd0;
              state              <= S_DONE;
              bus.data_result    <= fin_result;
              bus.data_exception <= fin_exc;
              bus.data_resultRDY <= 1'b1;
            end else begin
              counter <= counter + 5'd1;
            end
          end
          S_DONE: begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed-vector bench for multdiv_iter: latency, results, exceptions, restart and reset.
// Expected values are hand-computed signed products/quotients.
module tb_multdiv_iter;

  logic clock;
  logic reset_n;
  int   errors;
  int   checks;

  multdiv_iter_if bus ();

  multdiv_iter #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives a one-cycle start pulse; returns at the negedge just after the start edge.
  task automatic applyStimulus(input logic mult, input logic div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = mult;
    bus.ctrl_DIV      = div;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
  endtask

  // Waits for RDY (bounded), then checks latency, result, exception, pulse width and hold.
  task automatic runAndCheck(input string tag, input logic [31:0] expResult, input logic expExc);
    int cnt;
    cnt = 1;
    while (!bus.data_resultRDY && cnt < 60) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput({tag, "_lat"}, 32'(cnt), 32'd33);
    checkOutput({tag, "_res"}, bus.data_result, expResult);
    checkOutput({tag, "_exc"}, 32'(bus.data_exception), 32'(expExc));
    @(negedge clock);
    checkOutput({tag, "_rdyw"}, 32'(bus.data_resultRDY), 32'd0);
    checkOutput({tag, "_idle"}, 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clock);
    checkOutput({tag, "_hold"}, bus.data_result, expResult);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic sawRdy;
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_rdy",  32'(bus.data_resultRDY), 32'd0);
    checkOutput("rst_res",  bus.data_result, 32'd0);
    checkOutput("rst_exc",  32'(bus.data_exception), 32'd0);
    reset_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    checkOutput("mul1_busy", 32'(bus.busy), 32'd1);
    runAndCheck("mul_7_m3", 32'hFFFF_FFEB, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    runAndCheck("mul_ovf", 32'h0000_0000, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'd1);
    runAndCheck("mul_min_1", 32'h8000_0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    runAndCheck("mul_min_min", 32'h0000_0000, 1'b1);

    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    runAndCheck("div_m7_2", 32'hFFFF_FFFD, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    runAndCheck("div_100_m7", 32'hFFFF_FFF2, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd5, 32'd0);
    runAndCheck("div_by0", 32'h0000_0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    runAndCheck("div_min_m1", 32'h8000_0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'd1);
    runAndCheck("div_min_1", 32'h8000_0000, 1'b0);

    // Restart: MUL aborted by a DIV ten cycles later.
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
    sawRdy = 1'b0;
    repeat (8) begin
      @(negedge clock);
      sawRdy = sawRdy | bus.data_resultRDY;
    end
    checkOutput("restart_early_rdy", 32'(sawRdy), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd20, 32'd5);
    runAndCheck("restart_div", 32'd4, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'd6, 32'd3);
    runAndCheck("both_start", 32'd18, 1'b0);

    // Asynchronous reset in the middle of an operation.
    applyStimulus(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0ABC);
    repeat (15) @(negedge clock);
    checkOutput("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_rdy",  32'(bus.data_resultRDY), 32'd0);
    checkOutput("midrst_res",  bus.data_result, 32'd0);
    checkOutput("midrst_exc",  32'(bus.data_exception), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runAndCheck("mul_m1_m1", 32'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
